ks_mem_arbiter: RTL and testbench
=================================

Name: ks_mem_arbiter

Overview:
- Shares the single-port K&S data RAM between two requesters: the core datapath (instruction fetch, LOAD, STORE) and a host port used for program loading and debug.
- Fair round-robin arbitration, one access per cycle, sync-read RAM with 1-cycle latency.
- Lock handshake lets the host take exclusive ownership of the RAM while the core is held off.
- Sits between the datapath/control unit memory interface and the RAM.

Parameters:
- ADDR_WIDTH, 5, RAM word address width.
- DATA_WIDTH, 16, RAM word width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_WIDTH  core word address
- core_wdata  in  DATA_WIDTH  core write data
- core_gnt  out  1  core access accepted this cycle (combinational)
- core_rvalid  out  1  core read data valid (registered)
- core_rdata  out  DATA_WIDTH  core read data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  host equivalents of the core request signals
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_WIDTH  host read data
- host_lock_req  in  1  host requests exclusive RAM ownership
- host_lock_ack  out  1  exclusive ownership granted (registered)
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after address

Behaviour:
- Reset values:
  - All gnt, rvalid, ram_we and host_lock_ack outputs = 0; rdata = 0.
  - Round-robin pointer last_winner = HOST, so the core wins the first tie.
  - State = ARB_RR.
- Arbitration is combinational within the cycle.
  - At most one gnt is high per cycle.
  - ram_addr/ram_wdata/ram_we are muxed from the winner.
  - With no winner, ram_we = 0 and ram_addr holds its last value (registered mux select).
- ARB_RR:
  - Only one requester active -> that requester is granted.
  - Both active -> the requester not equal to last_winner is granted.
  - last_winner updates on every grant.
- Read pipeline:
  - A granted read (we = 0) in cycle N sets the matching rvalid = 1 in cycle N+1.
  - rdata = ram_rdata in N+1; rvalid is a 1-cycle pulse.
  - rdata holds its value when rvalid = 0.
  - A granted write produces no rvalid.
  - Back-to-back grants are allowed every cycle (full throughput).
- Lock state machine: ARB_RR -> ARB_DRAIN -> ARB_LOCKED -> ARB_RR.
  - ARB_RR: host_lock_req = 1 -> ARB_DRAIN next cycle. core_gnt is already forced to 0 in the cycle lock_req is seen.
  - ARB_DRAIN:
    - core_gnt = 0; host accesses still granted.
    - A core read issued in the previous cycle still returns core_rvalid.
    - No core read in flight -> ARB_LOCKED. Drain takes exactly 1 cycle.
  - ARB_LOCKED:
    - host_lock_ack = 1; core_gnt = 0; host granted whenever host_req is high.
    - host_lock_req = 0 -> host_lock_ack = 0 and ARB_RR next cycle; last_winner = HOST.
  - host_lock_req dropped during ARB_DRAIN -> return to ARB_RR without asserting ack.
- Simultaneous events:
  - host_lock_req rising with both requests active -> host granted.
  - A write and a read never coexist in a cycle (single port).
- Reset mid-operation: in-flight read is discarded (no rvalid after reset release); lock is released.
- Requesters must hold req, addr, we and wdata stable until gnt. The arbiter does not check this.

Optional Feature:
- Macro: KS_ARB_WAIT_CNT_EN.
- Defined:
  - Adds outputs core_wait_cnt and host_wait_cnt, 8 bits each.
  - Each counts cycles with req = 1 and gnt = 0 for that requester, saturating at 255.
  - Each clears to 0 on that requester's grant and on reset.
  - Cycles in ARB_LOCKED count for the core.
- Not defined: ports absent; arbitration identical.

Test Plan:
- Core read, addr 5'h03, RAM word 16'hBEEF -> core_gnt in cycle N, core_rvalid = 1 with core_rdata = 16'hBEEF in N+1, host signals idle.
- Both req held 4 cycles from reset, core read / host write -> grants alternate core, host, core, host. Only host cycles show ram_we = 1.
- Core read granted in cycle N, host_lock_req = 1 in N+1 -> core_rvalid in N+1, host_lock_ack = 1 by N+3. core_gnt stays 0 while locked although core_req = 1.
- In ARB_LOCKED, host writes 16'h1234 to 5'h1F then reads it back -> host_rvalid with 16'h1234. Drop lock_req -> ack 0 next cycle, core granted first on the next tie.
- Core read granted, rst_n low in the next cycle -> no core_rvalid after release, all outputs 0, state ARB_RR.
- With KS_ARB_WAIT_CNT_EN: host locked for 300 cycles with core_req = 1 -> core_wait_cnt saturates at 255, clears on the first core grant after unlock.

Source files
------------

// File: rtl/ks_mem_arbiter.sv
// ks_mem_arbiter
// ----------------------------------------------------------------------------
// Shares the single-port K&S data RAM between the core datapath (fetch, LOAD,
// STORE) and the host port (program load / debug).
// - Round-robin arbitration: one access per cycle.
// - The RAM has a synchronous read with 1-cycle latency.
// - A lock handshake gives the host exclusive ownership of the RAM.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   core_req/we/addr/wdata  core request; held stable until core_gnt
//   core_gnt                core access accepted this cycle (combinational)
//   core_rvalid/core_rdata  core read return, one cycle after the grant
//   host_req/we/addr/wdata  host request; held stable until host_gnt
//   host_gnt                host access accepted this cycle (combinational)
//   host_rvalid/host_rdata  host read return, one cycle after the grant
//   host_lock_req           host asks for exclusive RAM ownership
//   host_lock_ack           exclusive ownership held (registered)
//   ram_addr/wdata/we       RAM command, muxed from the winner
//   ram_rdata               RAM read data, valid one cycle after the address
//
// Optional build macro KS_ARB_WAIT_CNT_EN:
// - Adds core_wait_cnt and host_wait_cnt.
// - Each counter holds the number of cycles its requester has been kept
//   waiting. It saturates at 255 and clears on that requester's grant.
// ----------------------------------------------------------------------------
module ks_mem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  host_lock_req,
    output logic                  host_lock_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef KS_ARB_WAIT_CNT_EN
    ,
    output logic [7:0]            core_wait_cnt,
    output logic [7:0]            host_wait_cnt
`endif
);

    localparam logic [1:0] ARB_RR     = 2'd0;
    localparam logic [1:0] ARB_DRAIN  = 2'd1;
    localparam logic [1:0] ARB_LOCKED = 2'd2;

    localparam logic WIN_CORE = 1'b0;
    localparam logic WIN_HOST = 1'b1;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  last_winner_q;
    logic                  core_elig;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] wdata_hold_q;
    logic                  core_rd_vld_p1;
    logic                  host_rd_vld_p1;
    logic [DATA_WIDTH-1:0] core_rdata_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;
    logic                  lock_ack_q;

    // The core is held off in DRAIN and LOCKED.
    // It is also held off in the very cycle a lock request first shows up.
    assign core_elig = core_req && (state_q == ARB_RR) && !host_lock_req;

    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (core_elig && host_req) begin
            // Tie: the requester that did not win last time goes now.
            core_gnt = (last_winner_q == WIN_HOST);
            host_gnt = (last_winner_q == WIN_CORE);
        end else begin
            core_gnt = core_elig;
            host_gnt = host_req;
        end
    end

    // With no winner, the RAM address and write data keep their last values.
    always_comb begin
        ram_addr  = addr_hold_q;
        ram_wdata = wdata_hold_q;
        ram_we    = 1'b0;
        if (core_gnt) begin
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
            ram_we    = core_we;
        end else if (host_gnt) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            ram_we    = host_we;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_RR: begin
                if (host_lock_req) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                // A core read granted before the lock was seen must return first.
                if (!host_lock_req)      state_d = ARB_RR;
                else if (!core_rd_vld_p1) state_d = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                if (!host_lock_req) state_d = ARB_RR;
            end
            default: state_d = ARB_RR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_RR;
            last_winner_q <= WIN_HOST;
            addr_hold_q   <= '0;
            wdata_hold_q  <= '0;
            lock_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_ack_q <= (state_d == ARB_LOCKED);
            // Leaving the lock hands the next tie to the core.
            if (host_gnt || (state_q == ARB_LOCKED && !host_lock_req))
                last_winner_q <= WIN_HOST;
            else if (core_gnt)
                last_winner_q <= WIN_CORE;
            if (core_gnt || host_gnt) begin
                addr_hold_q  <= ram_addr;
                wdata_hold_q <= ram_wdata;
            end
        end
    end

    assign host_lock_ack = lock_ack_q;

    // ---- stage p1: RAM read return ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rd_vld_p1 <= 1'b0;
            host_rd_vld_p1 <= 1'b0;
            core_rdata_q   <= '0;
            host_rdata_q   <= '0;
        end else begin
            core_rd_vld_p1 <= core_gnt && !core_we;
            host_rd_vld_p1 <= host_gnt && !host_we;
            if (core_rd_vld_p1) core_rdata_q <= ram_rdata;
            if (host_rd_vld_p1) host_rdata_q <= ram_rdata;
        end
    end

    // Read data passes straight through in its valid cycle.
    // It is then held in a register until the next read returns.
    assign core_rvalid = core_rd_vld_p1;
    assign host_rvalid = host_rd_vld_p1;
    assign core_rdata  = core_rd_vld_p1 ? ram_rdata : core_rdata_q;
    assign host_rdata  = host_rd_vld_p1 ? ram_rdata : host_rdata_q;

`ifdef KS_ARB_WAIT_CNT_EN
    logic [7:0] core_wait_q;
    logic [7:0] host_wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_wait_q <= 8'd0;
            host_wait_q <= 8'd0;
        end else begin
            if (core_gnt)                              core_wait_q <= 8'd0;
            else if (core_req && core_wait_q != 8'hFF) core_wait_q <= core_wait_q + 8'd1;
            if (host_gnt)                              host_wait_q <= 8'd0;
            else if (host_req && host_wait_q != 8'hFF) host_wait_q <= host_wait_q + 8'd1;
        end
    end

    assign core_wait_cnt = core_wait_q;
    assign host_wait_cnt = host_wait_q;
`endif

endmodule

// File: tb/tb_ks_mem_arbiter.sv
// Testbench for ks_mem_arbiter.
// - A behavioural reference of the arbiter is checked against the DUT
//   outputs on every falling edge.
// - A directed sequence adds hand-computed literal checks on top of that.
// - A simple synchronous RAM model is attached to the RAM port.
module tb_ks_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, host_req, host_we, host_lock_req;
    logic [4:0]  core_addr, host_addr;
    logic [15:0] core_wdata, host_wdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid, host_lock_ack;
    logic [15:0] core_rdata, host_rdata;
    logic [4:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata = 16'h0;
`ifdef KS_ARB_WAIT_CNT_EN
    logic [7:0]  core_wait_cnt, host_wait_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ks_mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_lock_req(host_lock_req), .host_lock_ack(host_lock_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
`ifdef KS_ARB_WAIT_CNT_EN
        , .core_wait_cnt(core_wait_cnt), .host_wait_cnt(host_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Power-up contents of the RAM.
    function automatic logic [15:0] init_word(input logic [4:0] a);
        return (a == 5'h03) ? 16'hBEEF : (16'h1000 + {11'd0, a});
    endfunction

    // Synchronous single-port RAM with 1-cycle read latency.
    logic [15:0] mem [32];
    logic [31:0] written = 32'h0;
    always @(posedge clk) begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_word(ram_addr);
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Lock phase: 0 = round robin, 1 = draining, 2 = locked.
    int          m_phase;
    bit          m_last_host;
    bit          m_core_rv, m_host_rv;
    logic [15:0] m_core_rd, m_host_rd;
    logic [4:0]  m_addr;
    logic [15:0] m_mem [32];
    int          m_core_cnt, m_host_cnt;

    task automatic model_reset();
        m_phase     = 0;
        m_last_host = 1'b1;
        m_core_rv   = 1'b0;
        m_host_rv   = 1'b0;
        m_core_rd   = 16'h0;
        m_host_rd   = 16'h0;
        m_addr      = 5'h0;
        m_core_cnt  = 0;
        m_host_cnt  = 0;
    endtask

    initial begin
        bit          core_wants, e_cg, e_hg, e_we;
        logic [4:0]  e_addr;
        logic [15:0] e_wdata;
        for (int i = 0; i < 32; i++) m_mem[i] = init_word(i[4:0]);
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            core_wants = core_req && (m_phase == 0) && !host_lock_req;
            if (core_wants && host_req) begin
                e_cg = m_last_host;
                e_hg = !m_last_host;
            end else begin
                e_cg = core_wants;
                e_hg = host_req;
            end
            e_we    = (e_cg && core_we) || (e_hg && host_we);
            e_addr  = e_cg ? core_addr  : (e_hg ? host_addr  : m_addr);
            e_wdata = e_cg ? core_wdata : host_wdata;
            chk("core_gnt", core_gnt, e_cg);
            chk("host_gnt", host_gnt, e_hg);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            if (e_cg || e_hg) chk("ram_wdata", ram_wdata, e_wdata);
            chk("core_rvalid", core_rvalid, m_core_rv);
            chk("core_rdata", core_rdata, m_core_rd);
            chk("host_rvalid", host_rvalid, m_host_rv);
            chk("host_rdata", host_rdata, m_host_rd);
            chk("host_lock_ack", host_lock_ack, m_phase == 2);
`ifdef KS_ARB_WAIT_CNT_EN
            chk("core_wait_cnt", core_wait_cnt, m_core_cnt);
            chk("host_wait_cnt", host_wait_cnt, m_host_cnt);
`endif
            if (rst_n) begin
                // Read returns for next cycle come from memory before this cycle's write.
                m_core_rv = e_cg && !core_we;
                m_host_rv = e_hg && !host_we;
                if (m_core_rv) m_core_rd = m_mem[core_addr];
                if (m_host_rv) m_host_rd = m_mem[host_addr];
                if (e_cg && core_we) m_mem[core_addr] = core_wdata;
                if (e_hg && host_we) m_mem[host_addr] = host_wdata;
                if (e_cg) m_last_host = 1'b0;
                if (e_hg) m_last_host = 1'b1;
                if (e_cg || e_hg) m_addr = e_addr;
                if (e_cg) m_core_cnt = 0;
                else if (core_req && m_core_cnt < 255) m_core_cnt++;
                if (e_hg) m_host_cnt = 0;
                else if (host_req && m_host_cnt < 255) m_host_cnt++;
                case (m_phase)
                    0: if (host_lock_req) m_phase = 1;
                    1: m_phase = host_lock_req ? 2 : 0;
                    default: if (!host_lock_req) begin
                        m_phase     = 0;
                        m_last_host = 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 5'h0; core_wdata = 16'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 5'h0; host_wdata = 16'h0;
        host_lock_req = 1'b0;
        cyc();
        mid();
        chk("reset core_gnt", core_gnt, 1'b0);
        chk("reset core_rvalid", core_rvalid, 1'b0);
        chk("reset host_lock_ack", host_lock_ack, 1'b0);
        chk("reset core_rdata", core_rdata, 16'h0);
        chk("reset ram_we", ram_we, 1'b0);
        cyc(); rst_n = 1'b1;
        cyc();

        // Single core read of the BEEF word.
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'h03;
        mid(); chk("t1 gnt", core_gnt, 1'b1); chk("t1 host_gnt", host_gnt, 1'b0);
        cyc(); core_req = 1'b0;
        mid(); chk("t1 rvalid", core_rvalid, 1'b1); chk("t1 rdata", core_rdata, 16'hBEEF);
        chk("t1 host_rvalid", host_rvalid, 1'b0);
        cyc();
        mid(); chk("t1 rvalid pulse", core_rvalid, 1'b0); chk("t1 rdata hold", core_rdata, 16'hBEEF);

        // Both requesting from reset: core read vs host write alternate.
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'h01;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h02; host_wdata = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t2 core_gnt", core_gnt, (i % 2) == 0);
            chk("t2 host_gnt", host_gnt, (i % 2) == 1);
            chk("t2 ram_we", ram_we, (i % 2) == 1);
            cyc();
        end
        core_req = 1'b0; host_req = 1'b0; host_we = 1'b0;

        // Core read in flight when the lock request arrives.
        cyc();
        core_req = 1'b1; core_addr = 5'h03;
        mid(); chk("t3 gnt N", core_gnt, 1'b1);
        cyc(); host_lock_req = 1'b1;
        mid(); chk("t3 rvalid N+1", core_rvalid, 1'b1); chk("t3 gnt N+1", core_gnt, 1'b0);
        cyc();
        mid(); chk("t3 ack N+2", host_lock_ack, 1'b0); chk("t3 gnt N+2", core_gnt, 1'b0);
        cyc();
        mid(); chk("t3 ack N+3", host_lock_ack, 1'b1); chk("t3 gnt N+3", core_gnt, 1'b0);

        // Host write then read-back while locked, then release.
        cyc(); host_req = 1'b1; host_we = 1'b1; host_addr = 5'h1F; host_wdata = 16'h1234;
        mid(); chk("t4 wr gnt", host_gnt, 1'b1); chk("t4 wr we", ram_we, 1'b1);
        cyc(); host_we = 1'b0;
        mid(); chk("t4 rd gnt", host_gnt, 1'b1);
        cyc(); host_req = 1'b0;
        mid(); chk("t4 rvalid", host_rvalid, 1'b1); chk("t4 rdata", host_rdata, 16'h1234);
        chk("t4 core held", core_gnt, 1'b0);
        cyc(); host_lock_req = 1'b0;
        mid(); chk("t4 ack still", host_lock_ack, 1'b1);
        cyc(); host_req = 1'b1; host_addr = 5'h00;
        mid(); chk("t4 ack drop", host_lock_ack, 1'b0); chk("t4 core first", core_gnt, 1'b1);
        chk("t4 host waits", host_gnt, 1'b0);
        cyc(); core_req = 1'b0;
        mid(); chk("t4 host next", host_gnt, 1'b1);
        cyc(); host_req = 1'b0;

        // Reset while a core read is in flight.
        cyc(); core_req = 1'b1; core_addr = 5'h04;
        mid(); chk("t5 gnt", core_gnt, 1'b1);
        cyc(); core_req = 1'b0; rst_n = 1'b0;
        mid(); chk("t5 rvalid in reset", core_rvalid, 1'b0); chk("t5 rdata", core_rdata, 16'h0);
        cyc(); rst_n = 1'b1;
        mid(); chk("t5 rvalid after", core_rvalid, 1'b0); chk("t5 ack", host_lock_ack, 1'b0);
        cyc(); core_req = 1'b1; core_addr = 5'h08; host_req = 1'b1; host_addr = 5'h09;
        mid(); chk("t5 tie core", core_gnt, 1'b1); chk("t5 tie host", host_gnt, 1'b0);
        cyc(); core_req = 1'b0;
        mid(); chk("t5 host gnt", host_gnt, 1'b1); chk("t5 core rdata", core_rdata, 16'h1008);
        cyc(); host_req = 1'b0;
        mid(); chk("t5 host rdata", host_rdata, 16'h1009);

        // Lock request with both requesting; lock dropped during drain.
        cyc(); core_req = 1'b1; core_addr = 5'h06; host_req = 1'b1; host_addr = 5'h07;
        host_lock_req = 1'b1;
        mid(); chk("t6 host wins", host_gnt, 1'b1); chk("t6 core held", core_gnt, 1'b0);
        cyc(); host_req = 1'b0; host_lock_req = 1'b0;
        mid(); chk("t6 drain ack", host_lock_ack, 1'b0); chk("t6 drain core", core_gnt, 1'b0);
        cyc();
        mid(); chk("t6 back rr ack", host_lock_ack, 1'b0); chk("t6 back rr core", core_gnt, 1'b1);
        cyc(); core_req = 1'b0;
        mid(); chk("t6 rdata", core_rdata, 16'h1006);

`ifdef KS_ARB_WAIT_CNT_EN
        // Long lock: the core wait counter saturates, then clears on grant.
        cyc(); core_req = 1'b1; core_addr = 5'h05; host_lock_req = 1'b1;
        repeat (300) cyc();
        mid(); chk("t7 sat", core_wait_cnt, 8'd255); chk("t7 ack", host_lock_ack, 1'b1);
        cyc(); host_lock_req = 1'b0;
        cyc();
        mid(); chk("t7 gnt", core_gnt, 1'b1);
        cyc(); core_req = 1'b0;
        mid(); chk("t7 clear", core_wait_cnt, 8'd0);
`endif

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
